// File: rtl/dest_scoreboard.sv
// Destination-register scoreboard for a 5-stage in-order pipeline.
// Tracks the destinations in flight in EX/MEM/WB, detects load-use hazards
// against the instruction in ID, selects EX operand forwarding sources and
// counts stall cycles.
module dest_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  wr_dest,
    input  logic        wr_is_load,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [4:0]  wb_dest,
    output logic        wb_en,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Forwarding source for one EX operand; MEM wins over WB, r0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] mem_d,
                                           input logic [4:0] wb_d);
        logic [1:0] sel;
        if ((mem_d != 5'd0) && (mem_d == src)) begin
            sel = FWD_MEM;
        end else if ((wb_d != 5'd0) && (wb_d == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    logic [4:0] ex_dest_r;
    logic       ex_load_r;
    logic [4:0] ex_rs_r;
    logic [4:0] ex_rt_r;
    logic       ex_uses_rt_r;
    logic [4:0] mem_dest_r;
    logic       mem_load_r;
    logic [4:0] wb_dest_r;

    logic       hazard_s;
    logic       stall_s;
    logic       bubble_s;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    always_comb begin
        hazard_s = 1'b0;
        if (ex_load_r && (ex_dest_r != 5'd0)) begin
            if ((ex_dest_r == id_rs) || (id_uses_rt && (ex_dest_r == id_rt))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = 1'b0;
            end
        end else begin
            hazard_s = 1'b0;
        end
        stall_s  = hazard_s & id_valid & ~flush;
        bubble_s = stall_s | flush | ~id_valid;
    end

    // Pipeline slots: EX takes ID or a bubble, MEM and WB always advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_dest_r    <= 5'd0;
            ex_load_r    <= 1'b0;
            ex_rs_r      <= 5'd0;
            ex_rt_r      <= 5'd0;
            ex_uses_rt_r <= 1'b0;
            mem_dest_r   <= 5'd0;
            mem_load_r   <= 1'b0;
            wb_dest_r    <= 5'd0;
        end else begin
            if (bubble_s) begin
                ex_dest_r    <= 5'd0;
                ex_load_r    <= 1'b0;
                ex_rs_r      <= 5'd0;
                ex_rt_r      <= 5'd0;
                ex_uses_rt_r <= 1'b0;
            end else begin
                ex_dest_r    <= wr_dest;
                ex_load_r    <= wr_is_load;
                ex_rs_r      <= id_rs;
                ex_rt_r      <= id_rt;
                ex_uses_rt_r <= id_uses_rt;
            end
            mem_dest_r <= ex_dest_r;
            mem_load_r <= ex_load_r;
            wb_dest_r  <= mem_dest_r;
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (stall_s && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

    // Output decode from the slot registers and the current hazard.
    always_comb begin
        stall = stall_s;
        fwd_a = fwd_sel(ex_rs_r, mem_dest_r, wb_dest_r);
        if (ex_uses_rt_r) begin
            fwd_b = fwd_sel(ex_rt_r, mem_dest_r, wb_dest_r);
        end else begin
            fwd_b = FWD_RF;
        end
        wb_dest = wb_dest_r;
        wb_en   = (wb_dest_r != 5'd0);
    end

endmodule

// File: doc/dest_scoreboard.md
DEST_SCOREBOARD -- requirements
Module: dest_scoreboard

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, and SHALL use no other clock or reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 id_valid  input  1  a real instruction is present in ID.
REQ-005 id_rs  input  5  ID source register A.
REQ-006 id_rt  input  5  ID source register B.
REQ-007 id_uses_rt  input  1  ID instruction reads id_rt.
REQ-008 wr_dest  input  5  ID destination from the write-register select; 0 means no write (31 for JAL).
REQ-009 wr_is_load  input  1  ID instruction is LW.
REQ-010 flush  input  1  squash the ID instruction this cycle.
REQ-011 stall  output  1  hold PC and IF/ID; combinational.
REQ-012 fwd_a  output  2  EX operand A source: 00 regfile, 01 MEM-stage result, 10 WB-stage result.
REQ-013 fwd_b  output  2  EX operand B source, same encoding as fwd_a.
REQ-014 wb_dest  output  5  register written this cycle.
REQ-015 wb_en  output  1  high when wb_dest != 0.
REQ-016 stall_cnt  output  16  count of stall cycles; saturating.

Function
REQ-017 Three stage slots SHALL be held: EX{dest,is_load,rs,rt,uses_rt}, MEM{dest,is_load}, WB{dest}.
REQ-018 The EX slot SHALL load on each clock as follows.
- If stall or flush is high, or id_valid is low: load a bubble (all fields 0).
- Otherwise: load {wr_dest, wr_is_load, id_rs, id_rt, id_uses_rt}.
REQ-019 MEM SHALL load from EX and WB SHALL load from MEM on every clock, regardless of stall.
REQ-020 The hazard condition SHALL be: EX.is_load AND EX.dest != 0 AND (EX.dest == id_rs OR (id_uses_rt AND EX.dest == id_rt)).
- stall = hazard AND id_valid AND NOT flush.
REQ-021 A load-use hazard SHALL produce exactly one stall cycle, because the bubble clears EX.
REQ-022 fwd_a SHALL be computed as follows.
- 01 if MEM.dest != 0 AND MEM.dest == EX.rs.
- Else 10 if WB.dest != 0 AND WB.dest == EX.rs.
- Else 00.
- MEM has priority when MEM and WB match together.
REQ-023 fwd_b SHALL follow the same rules using EX.rt, and SHALL be 00 when EX.uses_rt is 0.
REQ-024 Register 0 SHALL never cause a stall or a forward.
REQ-025 fwd_a and fwd_b SHALL be combinational from the slot registers only.
REQ-026 wb_dest SHALL equal WB.dest, and wb_en SHALL equal (WB.dest != 0).
REQ-027 stall_cnt SHALL increment on each clock where stall is 1 and SHALL saturate at 16'hFFFF.
REQ-028 Latency SHALL be as follows.
- A destination accepted at edge N appears in EX after edge N, in MEM after N+1, and on wb_dest after N+2.
REQ-029 When flush and a hazard occur together, stall SHALL be 0 and EX SHALL take a bubble.

Reset
REQ-030 While reset is high, all slots SHALL be 0, stall_cnt SHALL be 0, and the outputs SHALL be stall=0, fwd_a=fwd_b=00, wb_dest=0, wb_en=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight destinations, with no write-back pending after release.
REQ-032 The first clock edge after reset release SHALL follow REQ-018 normally.

Verification
REQ-033 The bench SHALL cover a load-use hazard.
- Stimulus: LW wr_dest=8, then an ID instruction with id_rs=8.
- Response: stall=1 for one cycle; stall_cnt=1; the next cycle has stall=0 and fwd_a=10.
REQ-034 The bench SHALL cover a back-to-back ALU sequence.
- Stimulus: wr_dest=5, then id_rs=5, id_rt=5, id_uses_rt=1.
- Response: no stall; in EX, fwd_a=01 and fwd_b=01.
REQ-035 The bench SHALL cover MEM/WB priority.
- Stimulus: two consecutive writes to 9, then a reader of 9.
- Response: fwd_a=01, not 10.
REQ-036 The bench SHALL cover JAL and register 0.
- Stimulus: wr_dest=31, then wr_dest=0 with id_rs=0.
- Response: wb_dest=31 with wb_en=1 two edges after the JAL's acceptance edge; the zero-destination instruction never produces wb_en, stall, or a forward.
REQ-037 The bench SHALL cover flush during a hazard.
- Stimulus: the REQ-033 hazard with flush=1.
- Response: stall=0; stall_cnt unchanged; EX is a bubble.
REQ-038 The bench SHALL cover reset with a load in MEM.
- Stimulus: assert reset while a load is in MEM.
- Response: wb_en=0 immediately and after release.
- Saturation: with stall_cnt forced to 16'hFFFF, a further stall leaves it at 16'hFFFF.
